// File: rtl/quad_decoder.sv
// Quadrature rotary encoder decoder with push button.
// Synchronises and debounces A/B/button, tracks the Gray-code phase, and emits
// one-clk step pulses per detent while keeping a wrapping position count.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   enc_a, enc_b         raw encoder phases (asynchronous, idle high)
//   enc_btn_n            raw push button (asynchronous, active low)
//   pos                  wrapping position count
//   step_cw, step_ccw    one-clk pulse per clockwise / counter-clockwise detent
//   btn_level            debounced button state, 1 = pressed
//   btn_press            one-clk pulse after btn_level rises
//   quad_err             one-clk pulse when A and B change in the same update
module quad_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES  = 12000,
    parameter int unsigned POS_WIDTH        = 12,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_btn_n,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_cw,
    output logic                 step_ccw,
    output logic                 btn_level,
    output logic                 btn_press,
    output logic                 quad_err
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IDX_A   = 0;
    localparam int unsigned IDX_B   = 1;
    localparam int unsigned IDX_BTN = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Detent thresholds in 4-bit signed so +4 is representable.
    localparam logic signed [3:0] STEP_P = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_N = -STEP_P;

    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       filt;
    logic [2:0]       filt_nxt;
    logic [CNT_W-1:0] cnt     [3];
    logic [CNT_W-1:0] cnt_nxt [3];

    logic [1:0]        q_cur;
    logic [1:0]        q_prev;
    logic [1:0]        q_delta;
    logic signed [2:0] acc;
    logic signed [2:0] acc_nxt;
    logic signed [3:0] acc_up;
    logic signed [3:0] acc_dn;
    logic [POS_WIDTH-1:0] pos_nxt;
    logic              cw_nxt;
    logic              ccw_nxt;
    logic              err_nxt;
    logic              btn_d;

    assign raw = {enc_btn_n, enc_b, enc_a};

    // Gray phase index along the CW sequence 11->01->00->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {~ab[0], ab[1] ^ ab[0]};
    endfunction

    assign q_cur   = {filt[IDX_A], filt[IDX_B]};
    assign q_delta = gray_idx(q_cur) - gray_idx(q_prev);

    // Debounce: filtered value follows sync only after DEBOUNCE_CYCLES stable mismatches.
    always_comb begin
        filt_nxt = filt;
        cnt_nxt  = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (sync2[i] != filt[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    filt_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Quadrature step accumulation; delta 1 = CW, 3 = CCW, 2 = illegal double change.
    always_comb begin
        acc_up  = {acc[2], acc} + 4'sd1;
        acc_dn  = {acc[2], acc} - 4'sd1;
        acc_nxt = acc;
        pos_nxt = pos;
        cw_nxt  = 1'b0;
        ccw_nxt = 1'b0;
        err_nxt = 1'b0;
        case (q_delta)
            2'd1: begin
                if (acc_up == STEP_P) begin
                    cw_nxt  = 1'b1;
                    pos_nxt = pos + POS_WIDTH'(1);
                    acc_nxt = '0;
                end else begin
                    acc_nxt = acc_up[2:0];
                end
            end
            2'd3: begin
                if (acc_dn == STEP_N) begin
                    ccw_nxt = 1'b1;
                    pos_nxt = pos - POS_WIDTH'(1);
                    acc_nxt = '0;
                end else begin
                    acc_nxt = acc_dn[2:0];
                end
            end
            2'd2: begin
                err_nxt = 1'b1;
                acc_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '1;
            sync2     <= '1;
            filt      <= '1;
            cnt       <= '{default: '0};
            q_prev    <= 2'b11;
            acc       <= '0;
            pos       <= '0;
            step_cw   <= 1'b0;
            step_ccw  <= 1'b0;
            quad_err  <= 1'b0;
            btn_level <= 1'b0;
            btn_d     <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            filt      <= filt_nxt;
            cnt       <= cnt_nxt;
            q_prev    <= q_cur;
            acc       <= acc_nxt;
            pos       <= pos_nxt;
            step_cw   <= cw_nxt;
            step_ccw  <= ccw_nxt;
            quad_err  <= err_nxt;
            btn_level <= ~filt_nxt[IDX_BTN];
            btn_d     <= btn_level;
            btn_press <= btn_level & ~btn_d;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: behavioural model checked every cycle plus
// hand-computed expectations on position and pulse counts.
module tb_quad_decoder;

    localparam int DEB = 4;
    localparam int PW  = 4;
    localparam int SPD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enc_a = 1'b1;
    logic          enc_b = 1'b1;
    logic          enc_btn_n = 1'b1;
    logic [PW-1:0] pos;
    logic          step_cw;
    logic          step_ccw;
    logic          btn_level;
    logic          btn_press;
    logic          quad_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cw_n = 0, ccw_n = 0, err_n = 0, press_n = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    quad_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .POS_WIDTH       (PW),
        .STEPS_PER_DETENT(SPD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_btn_n(enc_btn_n),
        .pos      (pos),
        .step_cw  (step_cw),
        .step_ccw (step_ccw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .quad_err (quad_err)
    );

    // Model state
    bit [1:0]     phase_tbl [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    bit           m_s1 [3];
    bit           m_s2 [3];
    bit           m_f  [3];
    bit [DEB-1:0] m_hist [3];
    bit [1:0]     m_qprev;
    int           m_acc, m_pos;
    bit           m_cw, m_ccw, m_err, m_lvl, m_lvl_old, m_press;

    function automatic int phase_of(input bit [1:0] ab);
        for (int k = 0; k < 4; k++) if (phase_tbl[k] == ab) return k;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit       rawv [3];
        bit       dv;
        bit [1:0] cur;
        int       ip, ic;
        rawv[0] = enc_a;
        rawv[1] = enc_b;
        rawv[2] = enc_btn_n;
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_f[i] = 1'b1; m_hist[i] = '1;
            end
            m_qprev = 2'b11; m_acc = 0; m_pos = 0;
            m_cw = 0; m_ccw = 0; m_err = 0; m_lvl = 0; m_lvl_old = 0; m_press = 0;
        end else begin
            cur = {m_f[0], m_f[1]};
            m_cw = 0; m_ccw = 0; m_err = 0;
            if (cur != m_qprev) begin
                ip = phase_of(m_qprev);
                ic = phase_of(cur);
                if (ic == (ip + 1) % 4) begin
                    m_acc = m_acc + 1;
                    if (m_acc == SPD) begin
                        m_cw = 1; m_pos = (m_pos + 1) % (1 << PW); m_acc = 0;
                    end
                end else if (ic == (ip + 3) % 4) begin
                    m_acc = m_acc - 1;
                    if (m_acc == -SPD) begin
                        m_ccw = 1; m_pos = (m_pos + (1 << PW) - 1) % (1 << PW); m_acc = 0;
                    end
                end else begin
                    m_err = 1; m_acc = 0;
                end
            end
            m_qprev   = cur;
            m_press   = m_lvl && !m_lvl_old;
            m_lvl_old = m_lvl;
            // Filtered input flips once the last DEB synchronised samples all disagree with it.
            for (int i = 0; i < 3; i++) begin
                dv = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = rawv[i];
                m_hist[i] = {m_hist[i][DEB-2:0], dv};
                if (m_f[i] && m_hist[i] == '0) m_f[i] = 1'b0;
                else if (!m_f[i] && m_hist[i] == '1) m_f[i] = 1'b1;
            end
            m_lvl = !m_f[2];
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            n_tests++;
            if (pos !== PW'(m_pos) || step_cw !== m_cw || step_ccw !== m_ccw ||
                quad_err !== m_err || btn_level !== m_lvl || btn_press !== m_press) begin
                n_fail++;
                $display("FAIL cycle t=%0t got pos=%0d cw=%b ccw=%b err=%b lvl=%b press=%b want pos=%0d cw=%b ccw=%b err=%b lvl=%b press=%b",
                         $time, pos, step_cw, step_ccw, quad_err, btn_level, btn_press,
                         m_pos, m_cw, m_ccw, m_err, m_lvl, m_press);
            end
            if (step_cw === 1'b1)   cw_n++;
            if (step_ccw === 1'b1)  ccw_n++;
            if (quad_err === 1'b1)  err_n++;
            if (btn_press === 1'b1) press_n++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit a, input bit b, input bit bn, input int n);
        enc_a = a; enc_b = b; enc_btn_n = bn;
        repeat (n) @(negedge clk);
    endtask

    task automatic cw_detent();
        drive(0, 1, 1, 10); drive(0, 0, 1, 10); drive(1, 0, 1, 10); drive(1, 1, 1, 10);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pos", int'(pos), 0);
        check("rst_pulses", int'({step_cw, step_ccw, btn_press, quad_err}), 0);
        check("rst_btn_level", int'(btn_level), 0);
        rst = 1'b0;
        drive(1, 1, 1, 5);

        cw_detent();
        check("cw1_pos", int'(pos), 1);
        check("cw1_count", cw_n, 1);
        repeat (15) cw_detent();
        check("cw16_wrap_pos", int'(pos), 0);
        check("cw16_count", cw_n, 16);
        check("cw16_no_ccw", ccw_n, 0);

        drive(1, 0, 1, 10); drive(0, 0, 1, 10); drive(0, 1, 1, 10); drive(1, 1, 1, 10);
        check("ccw_wrap_pos", int'(pos), 15);
        check("ccw_count", ccw_n, 1);
        drive(0, 1, 1, 10); drive(0, 0, 1, 10); drive(0, 1, 1, 10); drive(1, 1, 1, 10);
        check("reversal_pos", int'(pos), 15);
        check("reversal_pulses", cw_n + ccw_n, 17);

        drive(0, 1, 1, 3); drive(1, 1, 1, 12);
        check("glitch_pos", int'(pos), 15);
        check("glitch_pulses", cw_n + ccw_n + err_n, 17);

        drive(0, 0, 1, 10);
        check("double_err_count", err_n, 1);
        check("double_pos", int'(pos), 15);
        drive(1, 1, 1, 10);
        check("double_back_err_count", err_n, 2);

        drive(0, 1, 0, 10);
        check("btn_level_pressed", int'(btn_level), 1);
        check("btn_press_count", press_n, 1);
        drive(0, 0, 1, 10); drive(1, 0, 1, 10); drive(1, 1, 1, 10);
        check("btn_detent_cw_count", cw_n, 17);
        check("btn_detent_pos", int'(pos), 0);
        check("btn_released", int'(btn_level), 0);
        check("btn_release_no_press", press_n, 1);

        cw_detent();
        check("pre_reset_pos", int'(pos), 1);
        drive(0, 1, 1, 10); drive(0, 0, 1, 10); drive(1, 0, 1, 10);
        enc_a = 1; enc_b = 1; rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset_pos", int'(pos), 0);
        rst = 1'b0;
        drive(1, 1, 1, 10);
        drive(0, 1, 1, 10); drive(0, 0, 1, 10); drive(1, 0, 1, 10);
        check("after_reset_no_early_step", cw_n, 18);
        drive(1, 1, 1, 10);
        check("after_reset_full_detent", cw_n, 19);
        check("after_reset_pos", int'(pos), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
